// File: rtl/conv33_pim_feeder.sv
// conv33_pim_feeder
// Initiator-side sequencer for the 3x3 PIM convolution unit. A raster-order
// 6-bit pixel stream is turned into 3x3 windows using two line buffers. For
// every complete window the kernel address is swept from 0 to NUM_ADDR-1.
// Each address gets one Compute_flag pulse, the PIM result is captured, and
// the result is offered downstream tagged with its address.
//
// Handshakes: both ports are strict valid/ready. A transfer happens on a
// rising edge where valid and ready are both high. A valid source holds its
// data stable until that transfer, and valid never depends on ready.
//
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   pix_in/valid/ready     pixel input stream
//   in_data_0..8           window to PIM, row-major, _0 oldest, _8 newest
//   Add_pim, Compute_flag  PIM kernel address and compute strobe
//   out_data               PIM result, valid PIM_LAT cycles after the strobe
//   res_data/addr          captured result and the address that produced it
//   res_valid/ready        result output stream
//   frame_done             one-cycle pulse after the last result of a frame
module conv33_pim_feeder #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int NUM_ADDR = 32,
    parameter int PIM_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [5:0]  in_data_0,
    output logic [5:0]  in_data_1,
    output logic [5:0]  in_data_2,
    output logic [5:0]  in_data_3,
    output logic [5:0]  in_data_4,
    output logic [5:0]  in_data_5,
    output logic [5:0]  in_data_6,
    output logic [5:0]  in_data_7,
    output logic [5:0]  in_data_8,
    output logic [4:0]  Add_pim,
    output logic        Compute_flag,
    input  logic [17:0] out_data,
    output logic [17:0] res_data,
    output logic [4:0]  res_addr,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LW = (PIM_LAT > 1) ? $clog2(PIM_LAT) : 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [4:0]    ADDR_LAST = 5'(NUM_ADDR - 1);
    localparam logic [LW-1:0] WAIT_LAST = LW'(PIM_LAT - 1);

    typedef enum logic [1:0] {S_FILL, S_ISSUE, S_WAIT, S_HOLD} state_t;
    state_t state, state_next;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [LW-1:0] wait_cnt;
    logic [4:0]    addr;
    logic          last_win;      // current sweep belongs to the frame's last window
    logic [5:0]    lb1 [IMG_W];   // row r-1
    logic [5:0]    lb2 [IMG_W];   // row r-2
    logic [5:0]    win [9];       // running shift window, updated per pixel
    logic [5:0]    win_next [9];
    logic [5:0]    in_data [9];   // window frozen for the whole sweep

    logic accept, win_done, win_last, wait_last, addr_last;

    assign accept    = pix_valid & pix_ready;
    assign win_done  = (row >= RW'(2)) && (col >= CW'(2));
    assign win_last  = (row == ROW_LAST) && (col == COL_LAST);
    assign wait_last = (wait_cnt == WAIT_LAST);
    assign addr_last = (addr == ADDR_LAST);

    // Window after shifting in the current pixel column: top row from the
    // r-2 buffer, middle from r-1, bottom is the incoming pixel.
    always_comb begin
        win_next[0] = win[1];
        win_next[1] = win[2];
        win_next[2] = lb2[col];
        win_next[3] = win[4];
        win_next[4] = win[5];
        win_next[5] = lb1[col];
        win_next[6] = win[7];
        win_next[7] = win[8];
        win_next[8] = pix_in;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FILL;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_FILL:  if (accept && win_done) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (wait_last) state_next = S_HOLD;
            S_HOLD:  if (res_ready) state_next = addr_last ? S_FILL : S_ISSUE;
            default: state_next = S_FILL;
        endcase
    end

    // Output logic
    always_comb begin
        pix_ready    = (state == S_FILL);
        Compute_flag = (state == S_ISSUE);
        res_valid    = (state == S_HOLD);
    end

    assign Add_pim   = addr;
    assign in_data_0 = in_data[0];
    assign in_data_1 = in_data[1];
    assign in_data_2 = in_data[2];
    assign in_data_3 = in_data[3];
    assign in_data_4 = in_data[4];
    assign in_data_5 = in_data[5];
    assign in_data_6 = in_data[6];
    assign in_data_7 = in_data[7];
    assign in_data_8 = in_data[8];

    // Counters, sweep control and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            wait_cnt   <= '0;
            addr       <= '0;
            last_win   <= 1'b0;
            res_data   <= '0;
            res_addr   <= '0;
            frame_done <= 1'b0;
            for (int k = 0; k < 9; k++) in_data[k] <= '0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (win_done) begin
                    for (int k = 0; k < 9; k++) in_data[k] <= win_next[k];
                    addr     <= '0;
                    last_win <= win_last;
                end
            end
            if (state == S_ISSUE) wait_cnt <= '0;
            if (state == S_WAIT) begin
                if (wait_last) begin
                    res_data <= out_data;
                    res_addr <= addr;
                end else begin
                    wait_cnt <= wait_cnt + LW'(1);
                end
            end
            if (state == S_HOLD && res_ready) begin
                if (!addr_last)    addr       <= addr + 5'd1;
                else if (last_win) frame_done <= 1'b1;
            end
        end
    end

    // Pixel storage. Never read before being written for the current frame,
    // so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col] <= lb1[col];
            lb1[col] <= pix_in;
            for (int k = 0; k < 9; k++) win[k] <= win_next[k];
        end
    end
endmodule

// File: tb/tb_conv33_pim_feeder.sv
// Testbench for conv33_pim_feeder: 4x4 image, two kernel addresses. One
// instance uses PIM_LAT=1 with a driven res_ready, a second uses PIM_LAT=3
// with res_ready tied high. The PIM model returns the window sum plus the
// address, registered on Compute_flag.
module tb_conv33_pim_feeder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  pix_in, pix_in3;
    logic        pix_valid, pix_valid3;
    logic        pix_ready, pix_ready3;
    logic [5:0]  in_data [9];
    logic [5:0]  in_data3 [9];
    logic [4:0]  Add_pim, Add_pim3;
    logic        Compute_flag, Compute_flag3;
    logic [17:0] out_data = '0;
    logic [17:0] out_data3 = '0;
    logic [17:0] res_data, res_data3;
    logic [4:0]  res_addr, res_addr3;
    logic        res_valid, res_valid3;
    logic        res_ready;
    logic        frame_done, frame_done3;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int a = 0;
    int cf_n = 0;
    int fd_n = 0;
    int fd_cyc = 0;
    int hs_cyc = 0;
    logic [17:0] exp_q[$];
    logic [17:0] got_data_q[$];
    logic [4:0]  got_addr_q[$];
    logic [17:0] got3_data_q[$];
    logic [4:0]  got3_addr_q[$];
    int          cf3_q[$];

    always #5 clk = ~clk;

    conv33_pim_feeder #(.IMG_W(4), .IMG_H(4), .NUM_ADDR(2), .PIM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .in_data_0(in_data[0]), .in_data_1(in_data[1]), .in_data_2(in_data[2]),
        .in_data_3(in_data[3]), .in_data_4(in_data[4]), .in_data_5(in_data[5]),
        .in_data_6(in_data[6]), .in_data_7(in_data[7]), .in_data_8(in_data[8]),
        .Add_pim(Add_pim), .Compute_flag(Compute_flag), .out_data(out_data),
        .res_data(res_data), .res_addr(res_addr), .res_valid(res_valid),
        .res_ready(res_ready), .frame_done(frame_done)
    );

    conv33_pim_feeder #(.IMG_W(4), .IMG_H(4), .NUM_ADDR(2), .PIM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .pix_in(pix_in3), .pix_valid(pix_valid3), .pix_ready(pix_ready3),
        .in_data_0(in_data3[0]), .in_data_1(in_data3[1]), .in_data_2(in_data3[2]),
        .in_data_3(in_data3[3]), .in_data_4(in_data3[4]), .in_data_5(in_data3[5]),
        .in_data_6(in_data3[6]), .in_data_7(in_data3[7]), .in_data_8(in_data3[8]),
        .Add_pim(Add_pim3), .Compute_flag(Compute_flag3), .out_data(out_data3),
        .res_data(res_data3), .res_addr(res_addr3), .res_valid(res_valid3),
        .res_ready(1'b1), .frame_done(frame_done3)
    );

    function automatic logic [17:0] pim_sum(input logic [5:0] d [9], input logic [4:0] ad);
        logic [17:0] s;
        s = 18'(ad);
        for (int k = 0; k < 9; k++) s = s + 18'(d[k]);
        return s;
    endfunction

    // PIM models
    always @(posedge clk) begin
        if (Compute_flag)  out_data  <= pim_sum(in_data, Add_pim);
        if (Compute_flag3) out_data3 <= pim_sum(in_data3, Add_pim3);
    end

    // Monitor: handshakes, strobes and frame_done, tagged with cycle number
    always @(posedge clk) begin
        if (res_valid && res_ready) begin
            got_data_q.push_back(res_data);
            got_addr_q.push_back(res_addr);
            hs_cyc = cyc;
        end
        if (frame_done) begin
            fd_n++;
            fd_cyc = cyc;
        end
        if (Compute_flag) cf_n++;
        if (res_valid3) begin
            got3_data_q.push_back(res_data3);
            got3_addr_q.push_back(res_addr3);
        end
        if (Compute_flag3) cf3_q.push_back(cyc);
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one pixel, wait (bounded) for acceptance. Returns at cycle a+1.
    task automatic send_px(input int sel, input int v);
        int n;
        n = 0;
        if (sel == 0) begin pix_in = 6'(v); pix_valid = 1'b1; end
        else          begin pix_in3 = 6'(v); pix_valid3 = 1'b1; end
        while (((sel == 0) ? !pix_ready : !pix_ready3) && n < 300) begin
            tick();
            n++;
        end
        chk("pix_accept_timeout", 32'(n < 300), 1);
        acc_cyc = cyc;
        tick();
        pix_valid = 1'b0;
        pix_valid3 = 1'b0;
    endtask

    task automatic wait_results(input int sel, input int count);
        int n;
        n = 0;
        while (((sel == 0) ? got_data_q.size() : got3_data_q.size()) < count && n < 1000) begin
            tick();
            n++;
        end
        chk("result_count", (sel == 0) ? got_data_q.size() : got3_data_q.size(), count);
    endtask

    task automatic check_frame_results();
        for (int k = 0; k < 8; k++) begin
            chk("res_data_seq", got_data_q[k], exp_q[k]);
            chk("res_addr_seq", got_addr_q[k], k % 2);
        end
        chk("frame_done_count", fd_n, 1);
        chk("frame_done_timing", fd_cyc, hs_cyc + 1);
        chk("compute_count", cf_n, 8);
    endtask

    initial begin
        exp_q = '{18'd45, 18'd46, 18'd54, 18'd55, 18'd81, 18'd82, 18'd90, 18'd91};
        rst_n = 1'b0;
        pix_in = '0; pix_valid = 1'b0; pix_in3 = '0; pix_valid3 = 1'b0;
        res_ready = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_compute_flag", Compute_flag, 0);
        chk("rst_add_pim", Add_pim, 0);
        chk("rst_in_data_0", in_data[0], 0);
        chk("rst_in_data_8", in_data[8], 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_addr", res_addr, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst3_pix_ready", pix_ready3, 1);
        rst_n = 1'b1;
        tick();

        // First window and latency
        for (int v = 0; v < 10; v++) send_px(0, v);
        chk("no_cf_before_window", cf_n, 0);
        send_px(0, 10);
        a = acc_cyc;
        chk("lat_cf_a1", Compute_flag, 1);
        chk("lat_add_pim_a1", Add_pim, 0);
        chk("win_in_data_0", in_data[0], 0);
        chk("win_in_data_4", in_data[4], 5);
        chk("win_in_data_8", in_data[8], 10);
        tick();
        chk("lat_cf_a2", Compute_flag, 0);
        chk("lat_rv_a2", res_valid, 0);
        chk("busy_pix_ready", pix_ready, 0);
        tick();
        chk("lat_rv_a3", res_valid, 1);
        chk("lat_data_a3", res_data, 45);
        chk("lat_addr_a3", res_addr, 0);

        // Back-pressure in HOLD
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_res_stable", {res_valid, res_data, res_addr}, {1'b1, 18'd45, 5'd0});
            chk("bp_ctl_stable", {pix_ready, Compute_flag, Add_pim, in_data[0], in_data[8]},
                {1'b0, 1'b0, 5'd0, 6'd0, 6'd10});
        end
        chk("bp_no_extra_cf", cf_n, 1);

        // Rest of frame 1 with res_ready high
        res_ready = 1'b1;
        for (int v = 11; v < 16; v++) send_px(0, v);
        wait_results(0, 8);
        repeat (3) tick();
        check_frame_results();

        // Frame 2: no window before pixel 10, then reset during WAIT
        for (int v = 0; v < 10; v++) send_px(0, v);
        chk("f2_no_cf_early", cf_n, 8);
        send_px(0, 10);
        chk("f2_cf_at_px10", Compute_flag, 1);
        tick();
        chk("pre_reset_wait", {pix_ready, Compute_flag, res_valid}, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pix_ready", pix_ready, 1);
        chk("mid_rst_res_data", res_data, 0);
        chk("mid_rst_res_addr", res_addr, 0);
        chk("mid_rst_in_data_8", in_data[8], 0);
        chk("mid_rst_ctl", {Compute_flag, res_valid, frame_done, Add_pim}, 0);
        repeat (2) tick();
        got_data_q.delete();
        got_addr_q.delete();
        fd_n = 0;
        cf_n = 0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_pix_ready", pix_ready, 1);
        chk("post_rst_res_valid", res_valid, 0);

        // Restream full frame
        for (int v = 0; v < 16; v++) send_px(0, v);
        wait_results(0, 8);
        repeat (3) tick();
        check_frame_results();

        // PIM_LAT=3 instance with res_ready tied high
        for (int v = 0; v < 16; v++) send_px(1, v);
        wait_results(1, 8);
        repeat (3) tick();
        chk("l3_cf_count", cf3_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk("l3_res_addr", got3_addr_q[k], k % 2);
            chk("l3_res_data", got3_data_q[k], exp_q[k]);
        end
        for (int w = 0; w < 4; w++) chk("l3_cf_spacing", cf3_q[2*w+1] - cf3_q[2*w], 5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
